// File: rtl/tick_sequencer_if.sv
// Configuration channel of tick_sequencer: half-period divisor, run mode and
// one-shot tick count, offered with a valid/ready handshake.
interface tick_sequencer_if #(
  parameter int unsigned CNT_W   = 26,
  parameter int unsigned TICKS_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div;
  logic               cfg_oneshot;
  logic [TICKS_W-1:0] cfg_nticks;

  modport master (
    output cfg_valid, cfg_div, cfg_oneshot, cfg_nticks,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_oneshot, cfg_nticks,
    output cfg_ready
  );
endinterface

// File: rtl/tick_sequencer.sv
// Run/pause/stop controller for the board time base: divides clk_50MHz by a
// run-time divisor into a one-cycle tick and a square clk_out, continuous or one-shot.
module tick_sequencer #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 25000000,
  parameter int unsigned TICKS_W     = 8
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  tick_sequencer_if.slave    cfg,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  output logic               tick,
  output logic               clk_out,
  output logic [TICKS_W-1:0] tick_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_e;

  typedef struct packed {
    logic [CNT_W-1:0]   div;
    logic               oneshot;
    logic [TICKS_W-1:0] nticks;
  } cfg_t;

  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : CNT_W'(DEFAULT_DIV);
  localparam cfg_t             RST_CFG = '{div: RST_DIV, oneshot: 1'b0, nticks: '0};

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q, tick_d;
  logic [TICKS_W-1:0] tick_cnt_q, tick_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  cfg_t               act_q, act_d;
  cfg_t               pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;

  cfg_t               cfg_in;
  logic               cfg_fire;
  logic               running;
  logic               terminal;
  logic [TICKS_W-1:0] tick_cnt_inc;

  // Pending is only ever occupied in RUN/PAUSED, so this is 1 in IDLE/DONE.
  assign cfg.cfg_ready = ~pend_valid_q;

  // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    cfg_in       = '{div: clamp_div(cfg.cfg_div), oneshot: cfg.cfg_oneshot, nticks: cfg.cfg_nticks};
    cfg_fire     = cfg.cfg_valid & ~pend_valid_q;
    running      = (state_q == S_RUN) || (state_q == S_PAUSED);
    terminal     = (cnt_q == act_q.div - CNT_W'(1));
    tick_cnt_inc = tick_cnt_q + TICKS_W'(1);

    state_d      = state_q;
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    tick_cnt_d   = tick_cnt_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (cfg_fire) begin
      if (running) begin
        pend_d       = cfg_in;
        pend_valid_d = 1'b1;
      end else begin
        act_d = cfg_in;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (stop || start) begin
          state_d    = stop ? S_IDLE : S_RUN;
          cnt_d      = '0;
          clk_out_d  = 1'b0;
          tick_cnt_d = '0;
        end
      end
      default: begin
        if (stop) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          clk_out_d    = 1'b0;
          tick_cnt_d   = '0;
          pend_valid_d = 1'b0;
          // A same-cycle offer is newer than anything already pending.
          if (cfg_fire) begin
            act_d = cfg_in;
          end else if (pend_valid_q) begin
            act_d = pend_q;
          end
        end else if (pause) begin
          state_d = S_PAUSED;
        end else begin
          state_d = S_RUN;
          if (terminal) begin
            tick_d     = 1'b1;
            clk_out_d  = ~clk_out_q;
            cnt_d      = '0;
            tick_cnt_d = tick_cnt_inc;
            if (act_q.oneshot && (act_q.nticks != '0) && (tick_cnt_inc == act_q.nticks)) begin
              state_d = S_DONE;
            end
            // Swapping here lets the next half-period start on the new divisor.
            if (pend_valid_q) begin
              act_d        = pend_q;
              pend_valid_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      tick_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      act_q        <= RST_CFG;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      tick_cnt_q   <= tick_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign tick     = tick_q;
  assign clk_out  = clk_out_q;
  assign tick_cnt = tick_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level behavioural model.
module tb_tick_sequencer;

  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int TICKS_W     = 4;
  localparam int TICK_MOD    = 1 << TICKS_W;

  logic               clk_50MHz = 1'b0;
  logic               reset;
  logic               start;
  logic               stop;
  logic               pause;
  logic               tick;
  logic               clk_out;
  logic [TICKS_W-1:0] tick_cnt;
  logic               busy;
  logic               done;

  int checks   = 0;
  int failures = 0;

  tick_sequencer_if #(.CNT_W(CNT_W), .TICKS_W(TICKS_W)) cfg_bus ();

  tick_sequencer #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .TICKS_W    (TICKS_W)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .cfg      (cfg_bus),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .tick     (tick),
    .clk_out  (clk_out),
    .tick_cnt (tick_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  // Behavioural model: a half-period is div advancing cycles; a queue holds a deferred config.
  typedef struct {
    int div;
    bit oneshot;
    int nticks;
  } cfg_m_t;

  cfg_m_t m_cfg;
  cfg_m_t m_pend[$];
  bit     m_busy, m_done, m_level, m_tick;
  int     m_pos, m_ticks;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_cfg   = '{DEFAULT_DIV, 1'b0, 0};
    m_pend.delete();
    m_busy  = 0;
    m_done  = 0;
    m_level = 0;
    m_tick  = 0;
    m_pos   = 0;
    m_ticks = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit     fire     = cfg_bus.cfg_valid && (m_pend.size() == 0);
    bit     had_pend = (m_pend.size() != 0);
    cfg_m_t offered  = '{clamp(int'(cfg_bus.cfg_div)), cfg_bus.cfg_oneshot, int'(cfg_bus.cfg_nticks)};
    m_tick = 0;
    if (!m_busy) begin
      if (fire) m_cfg = offered;
      if (stop || start) begin
        m_busy  = !stop;
        m_done  = 0;
        m_pos   = 0;
        m_level = 0;
        m_ticks = 0;
      end
    end else if (stop) begin
      if (fire) m_cfg = offered;
      else if (had_pend) m_cfg = m_pend.pop_front();
      m_pend.delete();
      m_busy  = 0;
      m_pos   = 0;
      m_level = 0;
      m_ticks = 0;
    end else begin
      if (fire) m_pend.push_back(offered);
      if (!pause) begin
        m_pos++;
        if (m_pos == m_cfg.div) begin
          m_tick  = 1;
          m_pos   = 0;
          m_level = !m_level;
          m_ticks = (m_ticks + 1) % TICK_MOD;
          if (m_cfg.oneshot && m_cfg.nticks != 0 && m_ticks == m_cfg.nticks) begin
            m_busy = 0;
            m_done = 1;
          end
          if (had_pend) m_cfg = m_pend.pop_front();
        end
      end
    end
  endtask

  task automatic compare_all();
    check("tick",      tick,              m_tick);
    check("clk_out",   clk_out,           m_level);
    check("tick_cnt",  tick_cnt,          m_ticks);
    check("busy",      busy,              m_busy);
    check("done",      done,              m_done);
    check("cfg_ready", cfg_bus.cfg_ready, m_pend.size() == 0);
  endtask

  // One clock: model, edge, compare; start/stop/cfg_valid are one-cycle pulses.
  task automatic step();
    model_step();
    @(posedge clk_50MHz);
    #1;
    compare_all();
    start             = 1'b0;
    stop              = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic offer(input int d, input bit os, input int n);
    cfg_bus.cfg_valid   = 1'b1;
    cfg_bus.cfg_div     = CNT_W'(d);
    cfg_bus.cfg_oneshot = os;
    cfg_bus.cfg_nticks  = TICKS_W'(n);
    step();
  endtask

  // Cycles until the next tick, or -1 if none within the budget.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic held;

    reset               = 1'b1;
    start               = 1'b0;
    stop                = 1'b0;
    pause               = 1'b0;
    cfg_bus.cfg_valid   = 1'b0;
    cfg_bus.cfg_div     = '0;
    cfg_bus.cfg_oneshot = 1'b0;
    cfg_bus.cfg_nticks  = '0;
    model_reset();
    repeat (2) @(posedge clk_50MHz);
    #1;
    compare_all();
    check("rst_cfg_ready", cfg_bus.cfg_ready, 1);
    check("rst_busy", busy, 0);
    #2 reset = 1'b0;
    step();

    // Default divisor, continuous.
    start = 1'b1;
    step();
    wait_tick(n);
    check("t1_first_tick", n, 4);
    check("t1_clk_high", clk_out, 1);
    wait_tick(n);
    check("t1_second_tick", n, 4);
    check("t1_tick_cnt", tick_cnt, 2);
    check("t1_busy", busy, 1);
    stop = 1'b1;
    step();

    // One-shot: 5 ticks, 3 cycles apart.
    offer(3, 1'b1, 5);
    start = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      wait_tick(n);
      check("t2_spacing", n, 3);
    end
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_tick_cnt", tick_cnt, 5);
    bad = 0;
    repeat (10) begin
      step();
      if (tick !== 1'b0) bad++;
    end
    check("t2_extra_ticks", bad, 0);
    stop = 1'b1;
    step();

    // Divisor change mid half-period.
    offer(4, 1'b0, 0);
    start = 1'b1;
    step();
    wait_tick(n);
    check("t3_first_tick", n, 4);
    step();
    offer(2, 1'b0, 0);
    check("t3_ready_low", cfg_bus.cfg_ready, 0);
    wait_tick(n);
    check("t3_old_half", n + 2, 4);
    wait_tick(n);
    check("t3_new_half_a", n, 2);
    wait_tick(n);
    check("t3_new_half_b", n, 2);
    check("t3_ready_back", cfg_bus.cfg_ready, 1);

    // Pause at cnt = 2 for 10 cycles.
    stop = 1'b1;
    step();
    offer(4, 1'b0, 0);
    start = 1'b1;
    step();
    wait_tick(n);
    check("t4_first_tick", n, 4);
    step();
    step();
    held  = clk_out;
    pause = 1'b1;
    bad   = 0;
    repeat (10) begin
      step();
      if (tick !== 1'b0 || clk_out !== held) bad++;
    end
    check("t4_pause_hold", bad, 0);
    pause = 1'b0;
    wait_tick(n);
    check("t4_resume_tick", n, 2);

    // Stop on a terminal-count cycle.
    wait_tick(n);
    check("t5_tick", n, 4);
    check("t5_clk_high", clk_out, 1);
    repeat (3) step();
    stop = 1'b1;
    step();
    check("t5_no_tick", tick, 0);
    check("t5_busy", busy, 0);
    check("t5_clk_low", clk_out, 0);

    // Divisor 0 clamps to 2; asynchronous reset mid-run restores the default.
    offer(0, 1'b0, 0);
    start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      check("t6_clamped", n, 2);
    end
    step();
    #2 reset = 1'b1;
    #1;
    check("t6_rst_tick", tick, 0);
    check("t6_rst_clk", clk_out, 0);
    check("t6_rst_cnt", tick_cnt, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_ready", cfg_bus.cfg_ready, 1);
    model_reset();
    #1 reset = 1'b0;
    start = 1'b1;
    step();
    wait_tick(n);
    check("t6_default_div", n, 4);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      start               = ($urandom_range(0, 7) == 0);
      stop                = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) pause = ~pause;
      cfg_bus.cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_bus.cfg_div     = CNT_W'($urandom_range(0, 6));
      cfg_bus.cfg_oneshot = 1'($urandom_range(0, 1));
      cfg_bus.cfg_nticks  = TICKS_W'($urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
